// File: rtl/vga_sprite_engine.sv
`default_nettype none
// ============================================================================
// Module : vga_sprite_engine
// Brief  : Parametrised VGA timing generator with prioritised rectangle
//          sprites, optional dashed centre net and per-frame overlap report.
// Rev    : 1.0
// ============================================================================
module vga_sprite_engine #(
  parameter int         CLK_DIV       = 5,
  parameter int         H_VISIBLE     = 400,
  parameter int         H_FRONT       = 20,
  parameter int         H_SYNC        = 64,
  parameter int         H_BACK        = 44,
  parameter int         V_VISIBLE     = 600,
  parameter int         V_FRONT       = 1,
  parameter int         V_SYNC        = 4,
  parameter int         V_BACK        = 23,
  parameter bit         HSYNC_POL     = 1'b0,
  parameter bit         VSYNC_POL     = 1'b0,
  parameter int         NUM_SPRITES   = 3,
  parameter bit         NET_ENABLE    = 1'b1,
  parameter int         NET_X         = 199,
  parameter int         NET_WIDTH     = 2,
  parameter int         NET_DASH_LOG2 = 3,
  parameter logic [2:0] BG_COLOR      = 3'b000,
  parameter logic [2:0] NET_COLOR     = 3'b111,
  localparam int        H_TOTAL       = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int        V_TOTAL       = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int        HB            = $clog2(H_TOTAL),
  localparam int        VB            = $clog2(V_TOTAL)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SPRITES-1:0]    sprite_en,
  input  logic [NUM_SPRITES*HB-1:0] sprite_xmin,
  input  logic [NUM_SPRITES*HB-1:0] sprite_xmax,
  input  logic [NUM_SPRITES*VB-1:0] sprite_ymin,
  input  logic [NUM_SPRITES*VB-1:0] sprite_ymax,
  input  logic [NUM_SPRITES*3-1:0]  sprite_color,
  output logic [HB-1:0]             px_x,
  output logic [VB-1:0]             px_y,
  output logic                      frame_start,
  output logic [NUM_SPRITES-1:0]    overlap,
  output logic                      blank,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      r,
  output logic                      g,
  output logic                      b
);

  localparam int c_div_w = $clog2(CLK_DIV);

  logic [c_div_w-1:0]     r_div;
  logic [HB-1:0]          r_h;
  logic [VB-1:0]          r_v;
  logic [NUM_SPRITES-1:0] r_acc;

  logic                   w_pe;
  logic [31:0]            w_h32;
  logic [31:0]            w_v32;
  logic                   w_h_last;
  logic                   w_v_last;
  logic                   w_first;
  logic                   w_visible;
  logic                   w_hs_act;
  logic                   w_vs_act;
  logic                   w_net;
  logic [NUM_SPRITES-1:0] w_hit;
  logic                   w_multi;
  logic [NUM_SPRITES-1:0] w_contrib;
  logic [2:0]             w_color;

  assign w_pe      = (32'(r_div) == CLK_DIV - 1);
  assign w_h32     = 32'(r_h);
  assign w_v32     = 32'(r_v);
  assign w_h_last  = (w_h32 == H_TOTAL - 1);
  assign w_v_last  = (w_v32 == V_TOTAL - 1);
  assign w_first   = (r_h == '0) && (r_v == '0);
  assign w_visible = (w_h32 < H_VISIBLE) && (w_v32 < V_VISIBLE);
  assign w_hs_act  = (w_h32 >= H_VISIBLE + H_FRONT) &&
                     (w_h32 <  H_VISIBLE + H_FRONT + H_SYNC);
  assign w_vs_act  = (w_v32 >= V_VISIBLE + V_FRONT) &&
                     (w_v32 <  V_VISIBLE + V_FRONT + V_SYNC);

  // Net is dashed: drawn only on lines whose dash bit is clear.
  assign w_net = (w_h32 >= NET_X) && (w_h32 < NET_X + NET_WIDTH) &&
                 (((w_v32 >> NET_DASH_LOG2) & 32'd1) == 32'd0);

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_hit
    logic [HB-1:0] w_xmin;
    logic [HB-1:0] w_xmax;
    logic [VB-1:0] w_ymin;
    logic [VB-1:0] w_ymax;
    assign w_xmin   = sprite_xmin[i*HB +: HB];
    assign w_xmax   = sprite_xmax[i*HB +: HB];
    assign w_ymin   = sprite_ymin[i*VB +: VB];
    assign w_ymax   = sprite_ymax[i*VB +: VB];
    assign w_hit[i] = sprite_en[i] &
                      (r_h >= w_xmin) & (r_h <= w_xmax) &
                      (r_v >= w_ymin) & (r_v <= w_ymax);
  end

  // Clearing the lowest set bit leaves something only when two or more hit.
  assign w_multi   = |(w_hit & (w_hit - 1'b1));
  assign w_contrib = (w_visible && w_multi) ? w_hit : '0;

  always_comb begin
    w_color = BG_COLOR;
    if (NET_ENABLE && w_net) begin
      w_color = NET_COLOR;
    end
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_color = sprite_color[i*3 +: 3];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div       <= '0;
      r_h         <= '0;
      r_v         <= '0;
      r_acc       <= '0;
      px_x        <= '0;
      px_y        <= '0;
      frame_start <= 1'b0;
      overlap     <= '0;
      blank       <= 1'b1;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      {r, g, b}   <= 3'b000;
    end else begin
      frame_start <= 1'b0;
      if (w_pe) begin
        r_div       <= '0;
        r_h         <= w_h_last ? '0 : r_h + 1'b1;
        if (w_h_last) begin
          r_v <= w_v_last ? '0 : r_v + 1'b1;
        end
        px_x        <= r_h;
        px_y        <= r_v;
        frame_start <= w_first;
        blank       <= ~w_visible;
        hsync       <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
        vsync       <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
        {r, g, b}   <= w_visible ? w_color : 3'b000;
        // Pixel (0,0) publishes last frame and seeds the new accumulation.
        if (w_first) begin
          overlap <= r_acc;
          r_acc   <= w_contrib;
        end else begin
          r_acc   <= r_acc | w_contrib;
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_sprite_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_sprite_engine
// Brief  : Directed bench for vga_sprite_engine on a small 14x7 raster.
// Rev    : 1.0
// ============================================================================
module tb_vga_sprite_engine;

  localparam int HB = 4;
  localparam int VB = 3;
  localparam int NS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NS-1:0]    sprite_en;
  logic [NS*HB-1:0] sprite_xmin, sprite_xmax;
  logic [NS*VB-1:0] sprite_ymin, sprite_ymax;
  logic [NS*3-1:0]  sprite_color;
  logic [HB-1:0]    px_x;
  logic [VB-1:0]    px_y;
  logic             frame_start, blank, hsync, vsync, r, g, b;
  logic [NS-1:0]    overlap;

  logic [0:0]       b_sprite_en = '0;
  logic [HB-1:0]    b_xmin = '0, b_xmax = '0;
  logic [VB-1:0]    b_ymin = '0, b_ymax = '0;
  logic [2:0]       b_color = '0;
  logic [HB-1:0]    b_px_x;
  logic [VB-1:0]    b_px_y;
  logic             b_frame_start, b_blank, b_hsync, b_vsync, b_r, b_g, b_b;
  logic [0:0]       b_overlap;

  vga_sprite_engine #(
    .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .NUM_SPRITES(NS),
    .NET_ENABLE(1'b1), .NET_X(3), .NET_WIDTH(1), .NET_DASH_LOG2(1),
    .BG_COLOR(3'b000), .NET_COLOR(3'b111)
  ) dut (
    .clk(clk), .rst(rst), .sprite_en(sprite_en),
    .sprite_xmin(sprite_xmin), .sprite_xmax(sprite_xmax),
    .sprite_ymin(sprite_ymin), .sprite_ymax(sprite_ymax),
    .sprite_color(sprite_color), .px_x(px_x), .px_y(px_y),
    .frame_start(frame_start), .overlap(overlap), .blank(blank),
    .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b)
  );

  vga_sprite_engine #(
    .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .NUM_SPRITES(1),
    .NET_ENABLE(1'b0)
  ) dut_pol (
    .clk(clk), .rst(rst), .sprite_en(b_sprite_en),
    .sprite_xmin(b_xmin), .sprite_xmax(b_xmax),
    .sprite_ymin(b_ymin), .sprite_ymax(b_ymax),
    .sprite_color(b_color), .px_x(b_px_x), .px_y(b_px_y),
    .frame_start(b_frame_start), .overlap(b_overlap), .blank(b_blank),
    .hsync(b_hsync), .vsync(b_vsync), .r(b_r), .g(b_g), .b(b_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         x;
    int         y;
    logic [2:0] rgb;
    logic       bl;
    logic       hs;
    logic       vs;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_sprite(input int i, input logic en, input int x0, input int x1,
                            input int y0, input int y1, input logic [2:0] col);
    sprite_en[i]                = en;
    sprite_xmin[i*HB +: HB]     = HB'(x0);
    sprite_xmax[i*HB +: HB]     = HB'(x1);
    sprite_ymin[i*VB +: VB]     = VB'(y0);
    sprite_ymax[i*VB +: VB]     = VB'(y1);
    sprite_color[i*3 +: 3]      = col;
  endtask

  task automatic wait_fs(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!frame_start && cnt < 400);
  endtask

  task automatic wait_pixel(input int x, input int y);
    int n;
    n = 0;
    while (!(px_x == HB'(x) && px_y == VB'(y)) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("reach_px_%0d_%0d", x, y), 32'(n < 500), 32'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_blank"}, 32'(blank), 32'd1);
    chk({tag, "_hsync"}, 32'(hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync), 32'd1);
    chk({tag, "_rgb"}, 32'({r, g, b}), 32'd0);
    chk({tag, "_px"}, 32'({px_x, px_y}), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    chk({tag, "_pol_sync"}, 32'({b_hsync, b_vsync}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt, pix, mh, mv;
    int e_px, e_bl, e_hs, e_vs, e_rgb;
    int a_first, a_low, b_first, b_high, a_vlow;
    logic ebl, ehs, evs;

    // {x, y, rgb, blank, hsync, vsync}
    tbl[0]  = '{0,  0, 3'b000, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{3,  0, 3'b111, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{4,  0, 3'b000, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{5,  0, 3'b000, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{2,  1, 3'b100, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{3,  1, 3'b100, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{4,  1, 3'b010, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{5,  1, 3'b010, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{9,  1, 3'b000, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{10, 1, 3'b000, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{11, 1, 3'b000, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{12, 1, 3'b000, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{2,  2, 3'b100, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{3,  3, 3'b000, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{0,  5, 3'b000, 1'b1, 1'b1, 1'b0};

    sprite_en = '0; sprite_xmin = '0; sprite_xmax = '0;
    sprite_ymin = '0; sprite_ymax = '0; sprite_color = '0;
    set_sprite(0, 1'b1, 1, 3, 1, 2, 3'b100);
    set_sprite(1, 1'b1, 2, 5, 1, 1, 3'b010);
    set_sprite(2, 1'b1, 5, 3, 0, 3, 3'b001);

    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    chk("reset_overlap", 32'(overlap), 32'd0);

    rst = 1'b0;
    wait_fs(cnt);
    chk("first_fs_latency", 32'(cnt), 32'd2);
    chk("first_fs_px", 32'({px_x, px_y}), 32'd0);
    chk("first_fs_pol", 32'(b_frame_start), 32'd1);
    @(negedge clk);
    chk("fs_pulse_width", 32'(frame_start), 32'd0);
    wait_fs(cnt);
    chk("frame_period", 32'(cnt + 1), 32'd196);
    chk("overlap_frame1", 32'(overlap), 32'b011);

    for (int k = 0; k < 15; k++) begin
      wait_pixel(tbl[k].x, tbl[k].y);
      chk($sformatf("rgb_%0d_%0d", tbl[k].x, tbl[k].y), 32'({r, g, b}), 32'(tbl[k].rgb));
      chk($sformatf("blank_%0d_%0d", tbl[k].x, tbl[k].y), 32'(blank), 32'(tbl[k].bl));
      chk($sformatf("sync_%0d_%0d", tbl[k].x, tbl[k].y), 32'({hsync, vsync}),
          32'({tbl[k].hs, tbl[k].vs}));
    end

    wait_fs(cnt);
    chk("fs3_reached", 32'(cnt < 400), 32'd1);
    chk("overlap_frame2", 32'(overlap), 32'b011);
    set_sprite(1, 1'b1, 6, 7, 3, 3, 3'b010);

    e_px = 0; e_bl = 0; e_hs = 0; e_vs = 0; e_rgb = 0;
    a_first = -1; a_low = 0; b_first = -1; b_high = 0; a_vlow = 0;
    for (int i = 0; i < 196; i++) begin
      if (i > 0) @(negedge clk);
      pix = i / 2;
      mh  = pix % 14;
      mv  = pix / 14;
      ebl = (mh >= 8) || (mv >= 4);
      ehs = !(mh >= 10 && mh < 12);
      evs = (mv != 5);
      if (px_x != HB'(mh) || px_y != VB'(mv) || b_px_x != HB'(mh) || b_px_y != VB'(mv)) e_px++;
      if (blank != ebl || b_blank != ebl) e_bl++;
      if (hsync != ehs || b_hsync != !ehs) e_hs++;
      if (vsync != evs || b_vsync != !evs) e_vs++;
      if ((blank && {r, g, b} != 3'b000) || {b_r, b_g, b_b} != 3'b000) e_rgb++;
      if (i < 28) begin
        if (!hsync) begin
          if (a_first < 0) a_first = i;
          a_low++;
        end
        if (b_hsync) begin
          if (b_first < 0) b_first = i;
          b_high++;
        end
      end
      if (!vsync) a_vlow++;
    end
    chk("scan_px_errors", 32'(e_px), 32'd0);
    chk("scan_blank_errors", 32'(e_bl), 32'd0);
    chk("scan_hsync_errors", 32'(e_hs), 32'd0);
    chk("scan_vsync_errors", 32'(e_vs), 32'd0);
    chk("scan_rgb_in_blank", 32'(e_rgb), 32'd0);
    chk("hsync_low_start", 32'(a_first), 32'd20);
    chk("hsync_low_clks", 32'(a_low), 32'd4);
    chk("hsync_pol_high_start", 32'(b_first), 32'd20);
    chk("hsync_pol_high_clks", 32'(b_high), 32'd4);
    chk("vsync_low_clks", 32'(a_vlow), 32'd28);

    @(negedge clk);
    chk("fs4_on_time", 32'(frame_start), 32'd1);
    chk("overlap_apart", 32'(overlap), 32'b000);
    chk("overlap_pol", 32'(b_overlap), 32'd0);
    wait_pixel(4, 1);
    chk("rgb_moved_4_1", 32'({r, g, b}), 32'b000);
    wait_pixel(6, 3);
    chk("rgb_moved_6_3", 32'({r, g, b}), 32'b010);

    wait_fs(cnt);
    chk("overlap_frame4", 32'(overlap), 32'b000);
    set_sprite(1, 1'b1, 2, 5, 1, 1, 3'b010);
    wait_pixel(5, 2);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("midrst");
    chk("midrst_overlap", 32'(overlap), 32'd0);
    rst = 1'b0;
    wait_fs(cnt);
    chk("restart_latency", 32'(cnt), 32'd2);
    chk("restart_px", 32'({px_x, px_y}), 32'd0);
    chk("restart_no_partial", 32'(overlap), 32'b000);
    wait_fs(cnt);
    chk("restart_period", 32'(cnt), 32'd196);
    chk("overlap_after_restart", 32'(overlap), 32'b011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_sprite_engine.md
# vga_sprite_engine

Parametrised VGA timing generator and rectangle-sprite renderer, successor to the fixed 400x600 pong display block. It divides the system clock down to a pixel enable and generates fully parametrised horizontal/vertical timing with selectable sync polarity. It renders N colour sprites plus an optional dashed centre net with fixed priority, and reports per-frame sprite overlap to game logic. It sits between the game-state logic (paddles, ball, score sprites) and the VGA pins.

## Interface

Parameters:
- CLK_DIV, 5: system clocks per pixel (>=2)
- H_VISIBLE, 400; H_FRONT, 20; H_SYNC, 64; H_BACK, 44: horizontal timing in pixels
- V_VISIBLE, 600; V_FRONT, 1; V_SYNC, 4; V_BACK, 23: vertical timing in lines
- HSYNC_POL, 0; VSYNC_POL, 0: active sync level (0 = active-low)
- NUM_SPRITES, 3: sprite count (1..8)
- NET_ENABLE, 1; NET_X, 199; NET_WIDTH, 2; NET_DASH_LOG2, 3: net columns NET_X..NET_X+NET_WIDTH-1, drawn on lines where bit NET_DASH_LOG2 of line = 0
- BG_COLOR, 3'b000; NET_COLOR, 3'b111: {r,g,b}
- Derived: H_TOTAL, V_TOTAL = sum of the four fields; HB = $clog2(H_TOTAL), VB = $clog2(V_TOTAL)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- sprite_en  in  NUM_SPRITES  per-sprite enable
- sprite_xmin, sprite_xmax  in  NUM_SPRITES*HB  packed inclusive bounds, sprite i at [i*HB +: HB]
- sprite_ymin, sprite_ymax  in  NUM_SPRITES*VB  packed inclusive bounds
- sprite_color  in  NUM_SPRITES*3  packed {r,g,b}
- px_x  out  HB  column of pixel currently on r/g/b
- px_y  out  VB  line of pixel currently on r/g/b
- frame_start  out  1  one-clk pulse with pixel (0,0)
- overlap  out  NUM_SPRITES  sprites that overlapped another sprite last frame
- blank, hsync, vsync, r, g, b  out  1 each  VGA signals

## Operation

- Divider counts 0..CLK_DIV-1; pixel enable pe asserts on the clk where count = CLK_DIV-1.
- Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) advance on pe; h wraps to 0 and increments v; v wraps to 0 after V_TOTAL-1.
- On pe, all outputs register from the pre-increment (h,v); outputs hold for CLK_DIV clks.
- blank = (h >= H_VISIBLE) | (v >= V_VISIBLE).
- hsync = HSYNC_POL when H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC, else ~HSYNC_POL; vsync likewise on v.
- hit_i = sprite_en[i] & xmin_i<=h<=xmax_i & ymin_i<=v<=ymax_i; xmin>xmax or ymin>ymax never hits.
- Colour priority: lowest-index hit sprite, then net (if NET_ENABLE), then BG_COLOR. r/g/b = 0 when blank.
- Overlap: on each visible pe where >=2 hits, accumulator |= hit vector. On the pe outputting (0,0): overlap <= accumulator, accumulator <= that pixel's own contribution (clear + new).
- Sprite inputs sampled every pe; game logic updates them during frame_start or vblank to avoid tearing.

## Timing

- Reset values: divider, h, v, accumulator = 0; blank = 1; hsync = ~HSYNC_POL; vsync = ~VSYNC_POL; r,g,b = 0; px_x, px_y = 0; frame_start = 0; overlap = 0.
- First pe: CLK_DIV-th clk after rst deasserts; outputs then show pixel (0,0) with frame_start = 1 for one clk.
- Latency: 1 clk from pe to outputs; no other pipeline.
- Line = H_TOTAL*CLK_DIV clks; frame = V_TOTAL*H_TOTAL*CLK_DIV clks.
- rst mid-frame: all state returns to reset values on the next edge; the frame restarts at (0,0) with no partial overlap report.
- Simultaneous h and v wrap: handled in the same pe; the next output is (0,0).

## Test plan

- Small config (CLK_DIV=2, H 8/2/2/2, V 4/1/1/1): release rst -> first frame_start 2 clks later; next frame_start exactly 7*14*2 = 196 clks after it.
- Same config: hsync low for exactly 4 clks starting 20 clks after line start; vsync low for 28 clks on v=5; blank high on h>=8 or v>=4, with r/g/b = 0 throughout.
- HSYNC_POL=1: hsync idles low and pulses high over the same window.
- Sprite 0 {1..3,1..2} red, sprite 1 {2..5,1..1} green: pixel (2,1) = red; (4,1) = green; (2,2) = red; (0,0) = BG; next frame_start -> overlap = 2'b11.
- Sprites moved apart, one frame later -> overlap = 2'b00; a sprite with xmin=5, xmax=3 never draws.
- Net (NET_X=3, NET_WIDTH=1, NET_DASH_LOG2=1): column 3 drawn in NET_COLOR on v=0,1 and blank on v=2,3; assert rst at (5,2) -> outputs at reset values next clk, restart at (0,0).
